// File: rtl/tft_fifo_drain_ctrl_if.sv
// Signal bundle between the frame drain controller, the pixel SyncFIFO read port
// and the downstream TFT pixel stream. The master side is the drain controller.
interface tft_fifo_drain_ctrl_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int COORD_WIDTH = 9
);
    logic                   fifo_rd_en;
    logic [DATA_WIDTH-1:0]  fifo_data;
    logic                   fifo_empty;
    logic                   pix_valid;
    logic                   pix_ready;
    logic [DATA_WIDTH-1:0]  pix_data;
    logic [COORD_WIDTH-1:0] pix_x;
    logic [COORD_WIDTH-1:0] pix_y;
    logic                   pix_sof;
    logic                   pix_eol;

    modport master (
        output fifo_rd_en,
        input  fifo_data, fifo_empty,
        output pix_valid,
        input  pix_ready,
        output pix_data, pix_x, pix_y, pix_sof, pix_eol
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_data, fifo_empty,
        input  pix_valid,
        output pix_ready,
        input  pix_data, pix_x, pix_y, pix_sof, pix_eol
    );
endinterface

// File: rtl/tft_fifo_drain_ctrl.sv
// Frame-level FIFO drain: pops h_active*v_active words and streams them out with
// x/y coordinates and frame markers, hiding the FIFO read latency with a skid register.
module tft_fifo_drain_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int COORD_WIDTH = 9
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [COORD_WIDTH-1:0] h_active,
    input  logic [COORD_WIDTH-1:0] v_active,
    tft_fifo_drain_ctrl_if.master  bus,
    output logic                   busy,
    output logic                   frame_done,
    output logic [15:0]            underrun_cnt
);
    localparam int REQ_WIDTH = 2 * COORD_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                 state;
    logic [REQ_WIDTH-1:0]   req_left;
    logic [COORD_WIDTH-1:0] h_lat, v_lat;
    logic [COORD_WIDTH-1:0] nx, ny;
    logic                   inflight;
    logic                   skid_valid;
    logic [DATA_WIDTH-1:0]  skid_data;

    logic                   take;
    logic                   out_free;
    logic                   load_out;
    logic                   last_x;
    logic                   last_pix;
    logic [1:0]             occ;
    logic [DATA_WIDTH-1:0]  load_data;

    // NOTE: combinational helpers use blocking assignments and get a value on
    // every path, so no latch can be inferred.
    always_comb begin
        take      = bus.pix_valid && bus.pix_ready;
        out_free  = !bus.pix_valid || take;
        load_out  = out_free && (skid_valid || inflight);
        load_data = skid_valid ? skid_data : bus.fifo_data;
        last_x    = (nx == h_lat - 1'b1);
        last_pix  = take && (bus.pix_x == h_lat - 1'b1) && (bus.pix_y == v_lat - 1'b1);
        occ       = 2'(bus.pix_valid) + 2'(inflight) + 2'(skid_valid);
    end

    // Issue only while a slot will be free when the word lands; abort blocks the read
    // in its own cycle so nothing more is popped for a frame being dropped.
    assign bus.fifo_rd_en = (state == RUN) && !abort && !bus.fifo_empty &&
                            (req_left != '0) && ((occ - 2'(take)) < 2'd2);

    // NOTE: all state, including the data registers, is reset so every output
    // reads 0 the moment reset_n falls; sequential state uses non-blocking assignments.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            req_left      <= '0;
            h_lat         <= '0;
            v_lat         <= '0;
            nx            <= '0;
            ny            <= '0;
            inflight      <= 1'b0;
            skid_valid    <= 1'b0;
            skid_data     <= '0;
            bus.pix_valid <= 1'b0;
            bus.pix_data  <= '0;
            bus.pix_x     <= '0;
            bus.pix_y     <= '0;
            bus.pix_sof   <= 1'b0;
            bus.pix_eol   <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            underrun_cnt  <= '0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (h_active != '0 && v_active != '0) begin
                            state        <= RUN;
                            busy         <= 1'b1;
                            h_lat        <= h_active;
                            v_lat        <= v_active;
                            req_left     <= REQ_WIDTH'(h_active) * REQ_WIDTH'(v_active);
                            nx           <= '0;
                            ny           <= '0;
                            underrun_cnt <= '0;
                        end else begin
                            frame_done <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (bus.fifo_empty && req_left != '0 && !bus.pix_valid &&
                        underrun_cnt != 16'hFFFF) begin
                        underrun_cnt <= underrun_cnt + 1'b1;
                    end
                    if (abort) begin
                        state         <= FLUSH;
                        inflight      <= 1'b0;
                        skid_valid    <= 1'b0;
                        bus.pix_valid <= 1'b0;
                    end else begin
                        inflight <= bus.fifo_rd_en;
                        if (bus.fifo_rd_en) begin
                            req_left <= req_left - 1'b1;
                        end
                        if (last_pix) begin
                            state         <= IDLE;
                            busy          <= 1'b0;
                            frame_done    <= 1'b1;
                            bus.pix_valid <= 1'b0;
                            skid_valid    <= 1'b0;
                        end else begin
                            if (load_out) begin
                                bus.pix_valid <= 1'b1;
                                bus.pix_data  <= load_data;
                                bus.pix_x     <= nx;
                                bus.pix_y     <= ny;
                                bus.pix_sof   <= (nx == '0) && (ny == '0);
                                bus.pix_eol   <= last_x;
                                nx            <= last_x ? '0 : nx + 1'b1;
                                ny            <= last_x ? ny + 1'b1 : ny;
                            end else if (take) begin
                                bus.pix_valid <= 1'b0;
                            end
                            // Returning data parks in the skid register unless it goes straight out.
                            if (inflight && (skid_valid || !out_free)) begin
                                skid_data <= bus.fifo_data;
                            end
                            if (out_free) begin
                                skid_valid <= skid_valid && inflight;
                            end else begin
                                skid_valid <= skid_valid || inflight;
                            end
                        end
                    end
                end

                FLUSH: begin
                    state         <= IDLE;
                    busy          <= 1'b0;
                    inflight      <= 1'b0;
                    skid_valid    <= 1'b0;
                    bus.pix_valid <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tft_fifo_drain_ctrl.sv
// Directed bench for tft_fifo_drain_ctrl: a behavioural FIFO, a frame-level pixel model
// checked every cycle, and literal expectations for the listed scenarios.
module tb_tft_fifo_drain_ctrl;
    localparam int DW = 16;
    localparam int CW = 9;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic [CW-1:0] h_active;
    logic [CW-1:0] v_active;
    logic          busy;
    logic          frame_done;
    logic [15:0]   underrun_cnt;

    tft_fifo_drain_ctrl_if #(.DATA_WIDTH(DW), .COORD_WIDTH(CW)) bus ();

    tft_fifo_drain_ctrl #(.DATA_WIDTH(DW), .COORD_WIDTH(CW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .h_active     (h_active),
        .v_active     (v_active),
        .bus          (bus),
        .busy         (busy),
        .frame_done   (frame_done),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: one-cycle read latency, empty when pointers meet.
    logic [DW-1:0] mem [0:255];
    int            wr_ptr = 0;
    int            rd_ptr = 0;

    assign bus.fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (bus.fifo_rd_en && !bus.fifo_empty) begin
            bus.fifo_data <= mem[rd_ptr % 256];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    // Frame model: the k-th accepted pixel of a frame is the k-th word in the FIFO
    // at frame start, placed at (k % h, k / h).
    bit model_en = 1'b0;
    bit m_busy = 1'b0;
    bit done_pending = 1'b0;
    int m_h = 1, m_v = 1, m_idx = 0, m_reads = 0, m_base = 0, m_under = 0;

    logic [0:3] ready_pat = 4'b1001;
    bit         ready_pat_en = 1'b0;
    int         pat_idx = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int total;
        if (!model_en) return;
        total = m_h * m_v;
        check("frame_done", 32'(frame_done), 32'(done_pending));
        check("busy", 32'(busy), 32'(m_busy));
        check("underrun_cnt", 32'(underrun_cnt), m_under);
        if (!m_busy) begin
            check("idle_pix_valid", 32'(bus.pix_valid), 0);
            check("idle_rd_en", 32'(bus.fifo_rd_en), 0);
        end else begin
            if (bus.pix_valid) begin
                check("pix_data", 32'(bus.pix_data), 32'(mem[(m_base + m_idx) % 256]));
                check("pix_x", 32'(bus.pix_x), m_idx % m_h);
                check("pix_y", 32'(bus.pix_y), m_idx / m_h);
                check("pix_sof", 32'(bus.pix_sof), 32'(m_idx == 0));
                check("pix_eol", 32'(bus.pix_eol), 32'((m_idx % m_h) == m_h - 1));
            end
            check("buffered_le_2", 32'((m_reads - m_idx) <= 2), 1);
            if (bus.fifo_rd_en) begin
                check("rd_en_nonempty", 32'(bus.fifo_empty), 0);
                check("rd_en_in_budget", 32'(m_reads < total), 1);
            end
        end
        // Predict what the coming edge does.
        done_pending = 1'b0;
        if (m_busy) begin
            if (bus.fifo_empty && m_reads < total && !bus.pix_valid && m_under != 16'hFFFF)
                m_under++;
            if (bus.fifo_rd_en && !bus.fifo_empty) m_reads++;
            if (bus.pix_valid && bus.pix_ready) begin
                if (m_idx == total - 1) begin
                    done_pending = 1'b1;
                    m_busy       = 1'b0;
                end
                m_idx++;
            end
        end else if (start) begin
            if (h_active != '0 && v_active != '0) begin
                m_busy  = 1'b1;
                m_h     = int'(h_active);
                m_v     = int'(v_active);
                m_idx   = 0;
                m_reads = 0;
                m_base  = rd_ptr;
                m_under = 0;
            end else begin
                done_pending = 1'b1;
            end
        end
    endtask

    // One clock: model check on the falling edge, then return 1 time unit after the rising edge.
    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        if (ready_pat_en) begin
            bus.pix_ready = ready_pat[pat_idx];
            pat_idx       = (pat_idx + 1) % 4;
        end else begin
            bus.pix_ready = 1'b1;
        end
    endtask

    task automatic push(input logic [DW-1:0] d);
        mem[wr_ptr % 256] = d;
        wr_ptr++;
    endtask

    task automatic start_frame(input int h, input int v);
        h_active = CW'(h);
        v_active = CW'(v);
        start    = 1'b1;
        cycle();
        start    = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input int inject_k, output int vcnt,
                             output int done_at, output logic [DW-1:0] first_data);
        vcnt       = 0;
        done_at    = -1;
        first_data = '0;
        for (int k = 1; k <= max_cyc; k++) begin
            cycle();
            if (k == inject_k) begin
                start    = 1'b1;
                h_active = CW'(5);
                v_active = CW'(5);
            end else begin
                start = 1'b0;
            end
            if (bus.pix_valid) begin
                if (vcnt == 0) first_data = bus.pix_data;
                vcnt++;
            end
            if (frame_done) begin
                done_at = k;
                break;
            end
        end
        start = 1'b0;
        check("frame_done_seen", 32'(done_at > 0), 1);
    endtask

    int            vcnt, done_at, ptr0;
    logic [DW-1:0] first_data;

    initial begin
        reset_n       = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        h_active      = '0;
        v_active      = '0;
        bus.pix_ready = 1'b1;

        #3;
        check("rst_busy", 32'(busy), 0);
        check("rst_pix_valid", 32'(bus.pix_valid), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_underrun", 32'(underrun_cnt), 0);
        check("rst_rd_en", 32'(bus.fifo_rd_en), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        model_en = 1'b1;
        cycle();

        // Zero geometry: done pulse, nothing read, never busy.
        start_frame(0, 2);
        check("zero_geom_done", 32'(frame_done), 1);
        check("zero_geom_busy", 32'(busy), 0);
        repeat (2) cycle();

        // 4x2 at full rate.
        for (int i = 1; i <= 8; i++) push(DW'(i));
        ptr0 = rd_ptr;
        start_frame(4, 2);
        wait_done(100, 0, vcnt, done_at, first_data);
        check("4x2_valid_cycles", vcnt, 8);
        check("4x2_done_cycle", done_at, 10);
        check("4x2_first_data", 32'(first_data), 32'h0001);
        check("4x2_reads", rd_ptr - ptr0, 8);
        repeat (2) cycle();

        // 3x3 with ready pattern 1,0,0,1 and an ignored start mid-frame.
        for (int i = 1; i <= 9; i++) push(DW'(16'h0010 + i));
        ptr0 = rd_ptr;
        ready_pat_en = 1'b1;
        pat_idx      = 0;
        start_frame(3, 3);
        wait_done(200, 4, vcnt, done_at, first_data);
        ready_pat_en = 1'b0;
        check("3x3_first_data", 32'(first_data), 32'h0011);
        check("3x3_reads", rd_ptr - ptr0, 9);
        repeat (2) cycle();

        // 2x2 with the FIFO empty for 10 cycles after start.
        ptr0 = rd_ptr;
        start_frame(2, 2);
        repeat (10) cycle();
        check("underrun_10", 32'(underrun_cnt), 10);
        for (int i = 1; i <= 4; i++) push(DW'(16'h0020 + i));
        wait_done(100, 0, vcnt, done_at, first_data);
        check("2x2_first_data", 32'(first_data), 32'h0021);
        check("underrun_final", 32'(underrun_cnt), 10);
        check("2x2_reads", rd_ptr - ptr0, 4);
        repeat (2) cycle();

        // 8x1 aborted after the 3rd accepted pixel, then a 2x1 frame.
        for (int i = 1; i <= 10; i++) push(DW'(16'h0100 + i));
        ptr0 = rd_ptr;
        start_frame(8, 1);
        repeat (5) cycle();
        check("abort_pre_valid", 32'(bus.pix_valid), 1);
        check("abort_pre_x", 32'(bus.pix_x), 3);
        abort    = 1'b1;
        model_en = 1'b0;
        cycle();
        abort = 1'b0;
        check("abort_valid_low", 32'(bus.pix_valid), 0);
        check("abort_rd_en_low", 32'(bus.fifo_rd_en), 0);
        check("abort_no_done", 32'(frame_done), 0);
        check("abort_flush_busy", 32'(busy), 1);
        cycle();
        check("abort_idle", 32'(busy), 0);
        check("abort_no_done2", 32'(frame_done), 0);
        cycle();
        check("abort_no_done3", 32'(frame_done), 0);
        check("abort_words_popped", rd_ptr - ptr0, 5);
        m_busy       = 1'b0;
        done_pending = 1'b0;
        model_en     = 1'b1;
        start_frame(2, 1);
        wait_done(50, 0, vcnt, done_at, first_data);
        check("after_abort_first", 32'(first_data), 32'h0106);
        check("after_abort_reads", rd_ptr - ptr0, 7);
        repeat (2) cycle();

        // Asynchronous reset in the middle of a frame.
        for (int i = 1; i <= 4; i++) push(DW'(16'h0200 + i));
        start_frame(2, 2);
        repeat (3) cycle();
        check("pre_reset_valid", 32'(bus.pix_valid), 1);
        #2 reset_n = 1'b0;
        model_en = 1'b0;
        #1;
        check("arst_pix_valid", 32'(bus.pix_valid), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_rd_en", 32'(bus.fifo_rd_en), 0);
        check("arst_pix_data", 32'(bus.pix_data), 0);
        check("arst_pix_xy", 32'({bus.pix_x, bus.pix_y}), 0);
        check("arst_markers", 32'({bus.pix_sof, bus.pix_eol, frame_done}), 0);
        check("arst_underrun", 32'(underrun_cnt), 0);
        repeat (2) cycle();
        reset_n = 1'b1;
        cycle();
        check("post_reset_busy", 32'(busy), 0);
        check("post_reset_valid", 32'(bus.pix_valid), 0);
        check("post_reset_rd_en", 32'(bus.fifo_rd_en), 0);
        m_busy       = 1'b0;
        done_pending = 1'b0;
        m_under      = 0;
        model_en     = 1'b1;
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
